// File: rtl/comb_vector_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// comb_vector_checker
//
// Self-checking stimulus engine for a 3-input / 2-output combinational block.
// On a start pulse it walks the input vector {a,b,c} from 0 to 7. Each vector
// is held for SETTLE cycles. The block's y and d outputs are then sampled and
// compared against the EXP_Y / EXP_D truth tables, whose bit index is {a,b,c}.
// At the end of a run it reports pass/fail, a saturating count of failing
// vectors and the first failing vector.
//
// Parameters
//   SETTLE  cycles each vector is held before sampling (1..15)
//   EXP_Y   expected y truth table, bit index = {a,b,c}
//   EXP_D   expected d truth table, bit index = {a,b,c}
//   ERR_W   width of err_cnt (>= 4 for a count that can reach 8)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             single-cycle run request (ignored while busy)
//   a, b, c           stimulus vector bits 2, 1, 0 (registered, glitch-free)
//   y, d              outputs of the block under test
//   busy              run in progress (SETTLE or CHECK)
//   done              run complete, held until the next accepted start
//   pass              done and no failing vectors
//   err_cnt           number of failing vectors, saturates at all-ones
//   first_fail_valid  at least one vector failed in this run
//   first_fail_vec    {a,b,c} of the first failing vector
// -----------------------------------------------------------------------------
module comb_vector_checker #(
    parameter int unsigned SETTLE = 1,
    parameter logic [7:0]  EXP_Y  = 8'h00,
    parameter logic [7:0]  EXP_D  = 8'h00,
    parameter int unsigned ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Reload value of the settle down-counter: the SETTLE state lasts while
    // the counter runs from SETTLE-1 down to 0, i.e. exactly SETTLE cycles.
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
    localparam logic [2:0]       VEC_LAST    = 3'd7;

    state_e           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [2:0]       ffvec_q, ffvec_d;

    logic             mismatch;

    // A vector fails if either output disagrees; a double mismatch still
    // counts as a single failing vector.
    assign mismatch = (y != EXP_Y[vec_q]) || (d != EXP_D[vec_q]);

    // -------------------------------------------------------------------------
    // Next-state and run bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        unique case (state_q)
            // IDLE and DONE accept a start identically: results are cleared
            // and the walk restarts at vector 0.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    vec_d    = 3'd0;
                    settle_d = SETTLE_INIT;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = 3'd0;
                end
            end

            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_ONE;
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                // The vector advances on the same edge that samples it, so
                // the next vector gets a full settle window before its check.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + 3'd1;
                    settle_d = SETTLE_INIT;
                    state_d  = ST_SETTLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vec_q    <= 3'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: stimulus straight from the vector register, status decoded
    // from the state.
    // -------------------------------------------------------------------------
    assign a                = vec_q[2];
    assign b                = vec_q[1];
    assign c                = vec_q[0];
    assign busy             = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_q == '0);
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
